mc_processor_p: RTL

- Parametrised multicycle load/store processor, successor to the fixed 4-register core.
- Fetches one instruction per program-counter step from an external combinational instruction ROM and executes it against a parametrised register file.
- Talks to the cache/memory hierarchy over the shared rwToMem/rdEn/wtEn handshake.
- Adds ADD, BNZ branch, HALT, a completing ST, a memory-timeout error path and halted/error status outputs.

---
 rtl/proc_pkg.sv | 41 ++++
 rtl/mc_processor_p_if.sv | 15 +
 rtl/proc_regfile.sv | 36 +++
 rtl/mc_processor_p.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for mc_processor_p: opcodes, FSM states, memory request codes
// and instruction field offsets ({op[2:0], regIdx, imm}).
package proc_pkg;

    localparam int unsigned IOSTATEWIDTH = 2;

    typedef enum logic [IOSTATEWIDTH-1:0] {
        IO_IDLE = 2'd0,
        IO_RD   = 2'd1,
        IO_WT   = 2'd2
    } iostate_e;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXE   = 3'd1,
        S_MEM   = 3'd2,
        S_HALT  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    localparam logic [2:0] OP_LD   = 3'd0;
    localparam logic [2:0] OP_ST   = 3'd1;
    localparam logic [2:0] OP_NOP  = 3'd2;
    localparam logic [2:0] OP_SET  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_BNZ  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    function automatic int unsigned instr_width(input int unsigned riw, input int unsigned ww);
        return 3 + riw + ww;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned riw, input int unsigned ww);
        return riw + ww;
    endfunction

    function automatic int unsigned idx_lsb(input int unsigned ww);
        return ww;
    endfunction

endpackage

// File: rtl/mc_processor_p_if.sv
// Processor <-> cache/memory request/acknowledge bus.
interface mc_processor_p_if #(
    parameter int unsigned WORDWIDTH = 16,
    parameter int unsigned ADDRWIDTH = 16
);
    proc_pkg::iostate_e     rwToMem;
    logic [ADDRWIDTH-1:0]   addrToMem;
    logic [WORDWIDTH-1:0]   dataToMem;
    logic                   rdEn;
    logic                   wtEn;
    logic [WORDWIDTH-1:0]   dataFromMem;

    modport master (output rwToMem, addrToMem, dataToMem, input rdEn, wtEn, dataFromMem);
    modport slave  (input rwToMem, addrToMem, dataToMem, output rdEn, wtEn, dataFromMem);
endinterface

// File: rtl/proc_regfile.sv
// REGNUM x WORDWIDTH register file: one synchronous write port, one asynchronous
// read port, synchronous clear on reset. Out-of-range reads return zero.
module proc_regfile #(
    parameter int unsigned WORDWIDTH = 16,
    parameter int unsigned REGNUM    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(REGNUM)-1:0]   waddr,
    input  logic [WORDWIDTH-1:0]        wdata,
    input  logic [$clog2(REGNUM)-1:0]   raddr,
    output logic [WORDWIDTH-1:0]        rdata
);
    localparam int unsigned RIW1 = $clog2(REGNUM) + 1;

    logic [WORDWIDTH-1:0] regs_q [REGNUM];
    logic [WORDWIDTH-1:0] regs_d [REGNUM];

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REGNUM); i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Index widened by one bit so the range test stays meaningful for power-of-two REGNUM.
    assign rdata = ({1'b0, raddr} < RIW1'(REGNUM)) ? regs_q[raddr] : '0;

endmodule

// File: rtl/mc_processor_p.sv
// Multicycle load/store processor: FETCH/EXE/MEM/HALT/ERR with memory timeout.
// Optional retired-instruction counter built when MCPROC_PERF_CNT_EN is defined.
module mc_processor_p
    import proc_pkg::*;
#(
    parameter int unsigned WORDWIDTH   = 16,
    parameter int unsigned ADDRWIDTH   = 16,
    parameter int unsigned REGNUM      = 4,
    parameter int unsigned PCWIDTH     = 8,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [3+$clog2(REGNUM)+WORDWIDTH-1:0] instruction,
    output logic [PCWIDTH-1:0]                    pcCounter,
    output logic [WORDWIDTH-1:0]                  data,
    output logic                                  halted,
    output logic                                  error,
    mc_processor_p_if.master                      mem,
    output logic [31:0]                           retiredCnt
);
    localparam int unsigned RIW  = $clog2(REGNUM);
    localparam int unsigned RIW1 = RIW + 1;
    localparam int unsigned IW   = instr_width(RIW, WORDWIDTH);
    localparam int unsigned OPL  = op_lsb(RIW, WORDWIDTH);
    localparam int unsigned IDXL = idx_lsb(WORDWIDTH);
    localparam int unsigned TOW  = $clog2(MEM_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [PCWIDTH-1:0]   pc_q, pc_d;
    logic [IW-1:0]        ir_q, ir_d;
    logic [WORDWIDTH-1:0] data_q, data_d;
    iostate_e             rw_q, rw_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [WORDWIDTH-1:0] wdat_q, wdat_d;
    logic [TOW-1:0]       tmo_q, tmo_d;
    logic                 halted_q, halted_d;
    logic                 error_q, error_d;

    logic [2:0]           op_c;
    logic [RIW-1:0]       idx_c;
    logic [WORDWIDTH-1:0] imm_c;
    logic                 idx_ok_c;
    logic                 rf_we_c;
    logic [WORDWIDTH-1:0] rf_wdata_c;
    logic [WORDWIDTH-1:0] rf_rdata_c;

    assign op_c     = ir_q[OPL +: 3];
    assign idx_c    = ir_q[IDXL +: RIW];
    assign imm_c    = ir_q[0 +: WORDWIDTH];
    assign idx_ok_c = {1'b0, idx_c} < RIW1'(REGNUM);

    proc_regfile #(.WORDWIDTH(WORDWIDTH), .REGNUM(REGNUM)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we_c),
        .waddr (idx_c),
        .wdata (rf_wdata_c),
        .raddr (idx_c),
        .rdata (rf_rdata_c)
    );

    // Next-state and datapath updates; HALT/ERR hold everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        data_d     = data_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        tmo_d      = tmo_q;
        rf_we_c    = 1'b0;
        rf_wdata_c = '0;
        case (state_q)
            S_FETCH: begin
                ir_d    = instruction;
                pc_d    = pc_q + PCWIDTH'(1);
                state_d = S_EXE;
            end
            S_EXE: begin
                tmo_d   = '0;
                state_d = S_FETCH;
                if (!idx_ok_c) begin
                    state_d = S_ERR;
                end else begin
                    case (op_c)
                        OP_NOP: ;
                        OP_SET: begin
                            rf_we_c    = 1'b1;
                            rf_wdata_c = imm_c;
                            data_d     = imm_c;
                        end
                        OP_ADD: begin
                            rf_we_c    = 1'b1;
                            rf_wdata_c = rf_rdata_c + imm_c;
                            data_d     = rf_wdata_c;
                        end
                        OP_BNZ: if (rf_rdata_c != '0) pc_d = PCWIDTH'(imm_c);
                        OP_HALT: state_d = S_HALT;
                        OP_LD: begin
                            rw_d    = IO_RD;
                            addr_d  = ADDRWIDTH'(imm_c);
                            state_d = S_MEM;
                        end
                        OP_ST: begin
                            rw_d    = IO_WT;
                            addr_d  = ADDRWIDTH'(imm_c);
                            wdat_d  = rf_rdata_c;
                            state_d = S_MEM;
                        end
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_MEM: begin
                // Acknowledge is checked before the timeout so a last-cycle ack still completes.
                if ((rw_q == IO_RD) && mem.rdEn) begin
                    rf_we_c    = 1'b1;
                    rf_wdata_c = mem.dataFromMem;
                    data_d     = mem.dataFromMem;
                    rw_d       = IO_IDLE;
                    state_d    = S_FETCH;
                end else if ((rw_q == IO_WT) && mem.wtEn) begin
                    rw_d    = IO_IDLE;
                    state_d = S_FETCH;
                end else if (tmo_q == TOW'(MEM_TIMEOUT - 1)) begin
                    rw_d    = IO_IDLE;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TOW'(1);
                end
            end
            S_HALT, S_ERR: ;
            default: begin
                rw_d    = IO_IDLE;
                state_d = S_ERR;
            end
        endcase
        halted_d = (state_d == S_HALT);
        error_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            data_q   <= '0;
            rw_q     <= IO_IDLE;
            addr_q   <= '0;
            wdat_q   <= '0;
            tmo_q    <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            data_q   <= data_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            tmo_q    <= tmo_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    assign pcCounter     = pc_q;
    assign data          = data_q;
    assign halted        = halted_q;
    assign error         = error_q;
    assign mem.rwToMem   = rw_q;
    assign mem.addrToMem = addr_q;
    assign mem.dataToMem = wdat_q;

`ifdef MCPROC_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;

    // An instruction retires when EXE/MEM hands back to FETCH or enters HALT; saturating.
    always_comb begin
        retired_d = retired_q;
        if (((state_q == S_EXE) || (state_q == S_MEM)) &&
            ((state_d == S_FETCH) || (state_d == S_HALT)) && (retired_q != '1))
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retiredCnt = retired_q;
`else
    assign retiredCnt = '0;
`endif

endmodule
